// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcode constants and FSM state encoding for the ALU sequencer
package alu_seq_pkg;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;
    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} state_t;
endpackage

// File: rtl/alu_seq_ctrl_if.sv
// alu_seq_ctrl_if: operand/opcode request and result handshake between source and sequencer
interface alu_seq_ctrl_if #(parameter int WIDTH = 3);
    logic                 start;
    logic [WIDTH-1:0]     portA;
    logic [WIDTH-1:0]     portB;
    logic [1:0]           opcode;
    logic                 ready;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   result;
    logic                 neg;
    logic                 div_err;
    modport master (output start, portA, portB, opcode, input ready, busy, done, result, neg, div_err);
    modport slave  (input start, portA, portB, opcode, output ready, busy, done, result, neg, div_err);
endinterface

// File: rtl/alu_seq_iter.sv
// alu_seq_iter: one combinational step of shift-add multiply or restoring divide
module alu_seq_iter #(
    parameter int WIDTH = 3
) (
    input  logic                 i_div,
    input  logic [2*WIDTH-1:0]   i_acc,
    input  logic [2*WIDTH-1:0]   i_x,
    input  logic [WIDTH-1:0]     i_y,
    input  logic [WIDTH-1:0]     i_b,
    output logic [2*WIDTH-1:0]   o_acc,
    output logic [2*WIDTH-1:0]   o_x,
    output logic [WIDTH-1:0]     o_y
);
    logic [WIDTH:0]   w_t;
    logic [WIDTH-1:0] w_r;
    logic             w_ge;

    // mul: acc += lsb ? multiplicand : 0; div: shift next dividend bit into the remainder and trial-subtract
    always_comb begin
        w_t   = {i_acc[WIDTH-1:0], i_y[WIDTH-1]};
        w_ge  = w_t >= {1'b0, i_b};
        w_r   = w_ge ? WIDTH'(w_t - {1'b0, i_b}) : w_t[WIDTH-1:0];
        o_acc = i_div ? {{WIDTH{1'b0}}, w_r} : i_acc + (i_y[0] ? i_x : '0);
        o_x   = i_div ? i_x : i_x << 1;
        o_y   = i_div ? {i_y[WIDTH-2:0], w_ge} : i_y >> 1;
    end
endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-cycle add/sub/mul/div sequencer; ALU_SEQ_OPCNT_EN adds the op_count output
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    alu_seq_ctrl_if.slave      bus
`ifdef ALU_SEQ_OPCNT_EN
    ,
    output logic [CNT_W-1:0]   op_count
`endif
);
    localparam int CW = $clog2(WIDTH + 1);

    if (WIDTH < 2 || CNT_W < 1) begin : g_bad_params
        $error("alu_seq_ctrl: WIDTH must be >= 2 and CNT_W >= 1");
    end

    state_t              r_state, w_next;
    logic [1:0]          r_op;
    logic [WIDTH-1:0]    r_b, r_y, w_y;
    logic [2*WIDTH-1:0]  r_acc, r_x, w_acc, w_x, r_result, w_result;
    logic [CW-1:0]       r_cnt;
    logic                r_neg, r_err, w_neg, w_err, w_dz, w_last;

    // mul keeps A in r_x and B in r_y; div keeps the dividend in r_y and the remainder in r_acc
    alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
        .i_div (r_op[0]),
        .i_acc (r_acc),
        .i_x   (r_x),
        .i_y   (r_y),
        .i_b   (r_b),
        .o_acc (w_acc),
        .o_x   (w_x),
        .o_y   (w_y)
    );

    assign w_dz      = (r_op == OP_DIV) && (r_b == '0);
    assign w_last    = !r_op[1] || w_dz || (r_cnt == CW'(1));
    assign bus.ready = r_state == ST_IDLE;
    assign bus.busy  = r_state != ST_IDLE;
    assign bus.done  = r_state == ST_DONE;
    assign bus.result  = r_result;
    assign bus.neg     = r_neg;
    assign bus.div_err = r_err;

    // state register
    always_ff @(posedge clk) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    // next state plus the value to capture on entry to DONE
    always_comb begin
        w_next   = r_state == ST_IDLE ? (bus.start ? ST_EXEC : ST_IDLE)
                 : r_state == ST_EXEC ? (w_last ? ST_DONE : ST_EXEC) : ST_IDLE;
        w_result = '0;
        w_neg    = 1'b0;
        w_err    = 1'b0;
        case (r_op)
            OP_ADD: w_result = (2*WIDTH)'(r_x[WIDTH-1:0]) + (2*WIDTH)'(r_b);
            OP_SUB: begin
                w_neg    = r_x[WIDTH-1:0] < r_b;
                w_result = (2*WIDTH)'(w_neg ? r_b - r_x[WIDTH-1:0] : r_x[WIDTH-1:0] - r_b);
            end
            OP_MUL: w_result = w_acc;
            default: begin
                w_err    = w_dz;
                w_result = w_dz ? '0 : {w_acc[WIDTH-1:0], w_y};
            end
        endcase
    end

    // operand latch, iteration registers and result capture
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_op     <= OP_ADD;
            r_x      <= '0;
            r_y      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_neg    <= 1'b0;
            r_err    <= 1'b0;
        end else if (r_state == ST_IDLE && bus.start) begin
            r_op  <= bus.opcode;
            r_x   <= (2*WIDTH)'(bus.portA);
            r_y   <= bus.opcode == OP_DIV ? bus.portA : bus.portB;
            r_b   <= bus.portB;
            r_acc <= '0;
            r_cnt <= CW'(WIDTH);
        end else if (r_state == ST_EXEC) begin
            r_acc <= w_acc;
            r_x   <= w_x;
            r_y   <= w_y;
            r_cnt <= r_cnt - CW'(1);
            if (w_last) begin
                r_result <= w_result;
                r_neg    <= w_neg;
                r_err    <= w_err;
            end
        end
    end

`ifdef ALU_SEQ_OPCNT_EN
    // count every completed operation, divide-by-zero included
    always_ff @(posedge clk) begin
        if (!rst)                  op_count <= '0;
        else if (r_state == ST_DONE) op_count <= op_count + CNT_W'(1);
    end
`endif
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: randomized and directed checks of alu_seq_ctrl against a behavioural model
module tb_alu_seq_ctrl;
    localparam int W = 3;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    alu_seq_ctrl_if #(.WIDTH(W)) bus ();
`ifdef ALU_SEQ_OPCNT_EN
    logic [CNT_W-1:0] op_count;
`endif

    alu_seq_ctrl #(.WIDTH(W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef ALU_SEQ_OPCNT_EN
        ,
        .op_count (op_count)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    int m_left = 0, m_res = 0, m_neg = 0, m_err = 0, m_cnt = 0;
    int ma = 0, mb = 0, mop = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int exp_res(input int a, input int b, input int op);
        case (op)
            0: return a + b;
            1: return a >= b ? a - b : b - a;
            2: return a * b;
            default: return b == 0 ? 0 : (((a % b) << W) | (a / b));
        endcase
    endfunction

    // model: an accepted op keeps the unit busy for latency+1 cycles, the last being DONE
    always @(posedge clk) begin
        if (!rst) begin
            m_left = 0; m_res = 0; m_neg = 0; m_err = 0; m_cnt = 0;
        end else if (m_left > 0) begin
            if (m_left == 1) m_cnt = (m_cnt + 1) % (1 << CNT_W);
            m_left--;
            if (m_left == 1) begin
                m_res = exp_res(ma, mb, mop);
                m_neg = (mop == 1 && ma < mb) ? 1 : 0;
                m_err = (mop == 3 && mb == 0) ? 1 : 0;
            end
        end else if (bus.start) begin
            ma = int'(bus.portA); mb = int'(bus.portB); mop = int'(bus.opcode);
            m_left = (mop < 2 || (mop == 3 && mb == 0)) ? 2 : W + 1;
        end
    end

    // compare every cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", int'(bus.ready), m_left == 0 ? 1 : 0);
            check("busy", int'(bus.busy), m_left > 0 ? 1 : 0);
            check("done", int'(bus.done), m_left == 1 ? 1 : 0);
            check("result", int'(bus.result), m_res);
            check("neg", int'(bus.neg), m_neg);
            check("div_err", int'(bus.div_err), m_err);
`ifdef ALU_SEQ_OPCNT_EN
            check("op_count", int'(op_count), m_cnt);
`endif
        end
    end

    task automatic wait_ready();
        int k = 0;
        while (!bus.ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!bus.ready) begin
            n_bad++;
            $display("FAIL ready_timeout: ready still %0d after %0d cycles", bus.ready, k);
        end
    endtask

    task automatic run_op(input int a, input int b, input int op, input bit chk,
                          input int er, input int en, input int ed, input int el);
        int k;
        @(negedge clk);
        wait_ready();
        bus.portA = W'(a); bus.portB = W'(b); bus.opcode = 2'(op); bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.portA = W'($urandom); bus.portB = W'($urandom); bus.opcode = 2'($urandom);
        k = 1;
        while (!bus.done && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!bus.done) begin
            n_bad++;
            $display("FAIL done_timeout: no done within %0d cycles for op %0d", k, op);
        end else if (chk) begin
            check("lit_latency", k, el);
            check("lit_result", int'(bus.result), er);
            check("lit_neg", int'(bus.neg), en);
            check("lit_div_err", int'(bus.div_err), ed);
        end
    endtask

    task automatic run_rand();
        run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
               1'b0, 0, 0, 0, 0);
    endtask

    initial begin
        int nd;
        bus.start = 1'b0; bus.portA = '0; bus.portB = '0; bus.opcode = '0;
        repeat (2) @(posedge clk);
        #1 chk_en = 1;
        check("rst_ready", int'(bus.ready), 1);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_result", int'(bus.result), 0);
        @(negedge clk);
        rst = 1'b1;

        run_op(5, 3, 0, 1'b1, 8, 0, 0, 2);
        run_op(3, 5, 1, 1'b1, 2, 1, 0, 2);
        run_op(5, 3, 1, 1'b1, 2, 0, 0, 2);
        run_op(4, 4, 1, 1'b1, 0, 0, 0, 2);
        run_op(5, 3, 2, 1'b1, 15, 0, 0, 4);
        run_op(7, 7, 2, 1'b1, 49, 0, 0, 4);
        run_op(0, 6, 2, 1'b1, 0, 0, 0, 4);
        run_op(7, 2, 3, 1'b1, 6'b001_011, 0, 0, 4);
        run_op(5, 0, 3, 1'b1, 0, 0, 1, 2);
        run_op(5, 3, 0, 1'b1, 8, 0, 0, 2);

        // start re-pulsed mid-multiply must be ignored
        @(negedge clk);
        wait_ready();
        bus.portA = 3'd5; bus.portB = 3'd3; bus.opcode = 2'd2; bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk); bus.start = 1'b1; bus.portA = 3'd7; bus.portB = 3'd7;
        @(negedge clk); bus.start = 1'b0;
        nd = 0;
        repeat (8) begin
            nd += int'(bus.done);
            if (bus.done) check("lit_repulse_result", int'(bus.result), 15);
            @(negedge clk);
        end
        check("lit_repulse_dones", nd, 1);

        // reset in the second multiply cycle aborts without a done pulse
        wait_ready();
        bus.portA = 3'd7; bus.portB = 3'd7; bus.opcode = 2'd2; bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        check("lit_abort_ready", int'(bus.ready), 1);
        check("lit_abort_done", int'(bus.done), 0);
        check("lit_abort_result", int'(bus.result), 0);
        rst = 1'b1;
        run_op(6, 5, 2, 1'b1, 30, 0, 0, 4);

        for (int i = 2; i <= 256; i++) begin
            run_rand();
            @(negedge clk);
`ifdef ALU_SEQ_OPCNT_EN
            if (i == 3) check("lit_opcnt_3", int'(op_count), 3);
            if (i == 256) check("lit_opcnt_wrap", int'(op_count), 0);
`endif
        end
        for (int i = 0; i < 40; i++) run_rand();

        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
`ifdef ALU_SEQ_OPCNT_EN
        check("lit_opcnt_rst", int'(op_count), 0);
`endif
        check("lit_final_ready", int'(bus.ready), 1);
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
